// File: rtl/pseudo_float_frame_decoder_if.sv
// Handshake bundle for the pseudo-float frame decoder: element input stream
// and per-frame summary output stream.
interface pseudo_float_frame_decoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  exp_in;
    logic [2:0]  mant_in;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] out_sum;
    logic [10:0] out_max;
    logic [2:0]  out_argmax;
    logic [3:0]  out_count;
    logic        out_trunc;

    modport slave (
        input  in_valid, exp_in, mant_in, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_max, out_argmax, out_count, out_trunc
    );

    modport master (
        output in_valid, exp_in, mant_in, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_max, out_argmax, out_count, out_trunc
    );
endinterface

// File: rtl/pseudo_float_frame_decoder.sv
// Expands 3/3 pseudo-float elements to linear values and accumulates per-frame
// sum, max, argmax and count, presenting one registered summary per frame.
module pseudo_float_frame_decoder #(
    parameter int MAX_LEN = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    pseudo_float_frame_decoder_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [13:0] sum_reg, sum_next;
    logic [10:0] max_reg, max_next;
    logic [2:0]  argmax_reg, argmax_next;
    logic [3:0]  count_reg, count_next;

    logic        out_valid_reg, out_valid_next;
    logic [13:0] out_sum_reg, out_sum_next;
    logic [10:0] out_max_reg, out_max_next;
    logic [2:0]  out_argmax_reg, out_argmax_next;
    logic [3:0]  out_count_reg, out_count_next;
    logic        out_trunc_reg, out_trunc_next;

    logic [10:0] lin;
    logic        accept;
    logic        at_limit;
    logic        take_max;

    // Hidden leading one, then shift by the exponent: 8..1920.
    assign lin      = {7'd0, 1'b1, bus.mant_in} << bus.exp_in;
    assign accept   = bus.in_valid && bus.in_ready;
    assign at_limit = (count_reg == 4'(MAX_LEN - 1));
    // Strict compare keeps the lower index on ties.
    assign take_max = (count_reg == 4'd0) || (lin > max_reg);

    assign bus.in_ready   = (state_reg != REPORT);
    assign bus.out_valid  = out_valid_reg;
    assign bus.out_sum    = out_sum_reg;
    assign bus.out_max    = out_max_reg;
    assign bus.out_argmax = out_argmax_reg;
    assign bus.out_count  = out_count_reg;
    assign bus.out_trunc  = out_trunc_reg;

    always_comb begin
        state_next      = state_reg;
        sum_next        = sum_reg;
        max_next        = max_reg;
        argmax_next     = argmax_reg;
        count_next      = count_reg;
        out_valid_next  = out_valid_reg;
        out_sum_next    = out_sum_reg;
        out_max_next    = out_max_reg;
        out_argmax_next = out_argmax_reg;
        out_count_next  = out_count_reg;
        out_trunc_next  = out_trunc_reg;

        case (state_reg)
            IDLE, ACCUM: begin
                if (accept) begin
                    sum_next   = sum_reg + 14'(lin);
                    count_next = count_reg + 4'd1;
                    if (take_max) begin
                        max_next    = lin;
                        argmax_next = count_reg[2:0];
                    end
                    if (bus.in_last || at_limit) begin
                        state_next      = REPORT;
                        out_valid_next  = 1'b1;
                        out_sum_next    = sum_next;
                        out_max_next    = max_next;
                        out_argmax_next = argmax_next;
                        out_count_next  = count_next;
                        out_trunc_next  = at_limit && !bus.in_last;
                    end else begin
                        state_next = ACCUM;
                    end
                end
            end
            REPORT: begin
                if (bus.out_ready) begin
                    state_next     = IDLE;
                    out_valid_next = 1'b0;
                    sum_next       = '0;
                    max_next       = '0;
                    argmax_next    = '0;
                    count_next     = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            sum_reg        <= '0;
            max_reg        <= '0;
            argmax_reg     <= '0;
            count_reg      <= '0;
            out_valid_reg  <= 1'b0;
            out_sum_reg    <= '0;
            out_max_reg    <= '0;
            out_argmax_reg <= '0;
            out_count_reg  <= '0;
            out_trunc_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            sum_reg        <= sum_next;
            max_reg        <= max_next;
            argmax_reg     <= argmax_next;
            count_reg      <= count_next;
            out_valid_reg  <= out_valid_next;
            out_sum_reg    <= out_sum_next;
            out_max_reg    <= out_max_next;
            out_argmax_reg <= out_argmax_next;
            out_count_reg  <= out_count_next;
            out_trunc_reg  <= out_trunc_next;
        end
    end

endmodule

// File: tb/tb_pseudo_float_frame_decoder.sv
// Directed plus randomized bench for pseudo_float_frame_decoder; expected
// summaries come from a queue-based frame model computed with plain arithmetic.
module tb_pseudo_float_frame_decoder;

    localparam int MAX_LEN = 8;

    logic clk;
    logic rst_n;

    pseudo_float_frame_decoder_if bus ();

    pseudo_float_frame_decoder #(.MAX_LEN(MAX_LEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    int lin_q[$];
    int exp_sum, exp_max, exp_argmax, exp_count, exp_trunc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int lin_of(input int e, input int m);
        return (8 + m) * (1 << e);
    endfunction

    // Frame statistics straight from the element list.
    task automatic summarise(input bit last);
        int s, mx, am;
        s  = 0;
        mx = -1;
        am = 0;
        foreach (lin_q[i]) begin
            s += lin_q[i];
            if (lin_q[i] > mx) begin
                mx = lin_q[i];
                am = i;
            end
        end
        exp_sum    = s;
        exp_max    = mx;
        exp_argmax = am;
        exp_count  = lin_q.size();
        exp_trunc  = (!last && lin_q.size() == MAX_LEN) ? 1 : 0;
    endtask

    task automatic check_summary(input string tag);
        chk({tag, "_valid"},  bus.out_valid, 1);
        chk({tag, "_ready"},  bus.in_ready, 0);
        chk({tag, "_sum"},    bus.out_sum, exp_sum);
        chk({tag, "_max"},    bus.out_max, exp_max);
        chk({tag, "_argmax"}, bus.out_argmax, exp_argmax);
        chk({tag, "_count"},  bus.out_count, exp_count);
        chk({tag, "_trunc"},  bus.out_trunc, exp_trunc);
        $display("summary %s: sum=%0d max=%0d argmax=%0d count=%0d trunc=%0d",
                 tag, bus.out_sum, bus.out_max, bus.out_argmax, bus.out_count, bus.out_trunc);
    endtask

    // Called at posedge+1 with the block able to accept.
    task automatic send(input int e, input int m, input bit last, output bit closed);
        chk("in_ready_before_beat", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.exp_in   = 3'(e);
        bus.mant_in  = 3'(m);
        bus.in_last  = last;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        lin_q.push_back(lin_of(e, m));
        closed = last || (lin_q.size() == MAX_LEN);
        if (closed) begin
            summarise(last);
            lin_q.delete();
            check_summary("close");
        end else begin
            chk("no_early_valid", bus.out_valid, 0);
        end
    endtask

    task automatic handshake(input int hold);
        repeat (hold) begin
            @(posedge clk);
            #1;
            check_summary("hold");
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("post_hs_valid", bus.out_valid, 0);
        chk("post_hs_ready", bus.in_ready, 1);
    endtask

    // Asynchronous reset pulse between edges; entered at posedge+1.
    task automatic pulse_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        chk({tag, "_valid"}, bus.out_valid, 0);
        chk({tag, "_ready"}, bus.in_ready, 1);
        chk({tag, "_sum"},   bus.out_sum, 0);
        chk({tag, "_count"}, bus.out_count, 0);
        #1;
        rst_n = 1'b1;
        lin_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit c;
        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.exp_in    = '0;
        bus.mant_in   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_valid",  bus.out_valid, 0);
        chk("reset_ready",  bus.in_ready, 1);
        chk("reset_sum",    bus.out_sum, 0);
        chk("reset_max",    bus.out_max, 0);
        chk("reset_argmax", bus.out_argmax, 0);
        chk("reset_count",  bus.out_count, 0);
        chk("reset_trunc",  bus.out_trunc, 0);
        #19;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic frame: 8 + 36 + 22.
        send(0, 0, 1'b0, c);
        send(2, 1, 1'b0, c);
        send(1, 3, 1'b1, c);
        handshake(0);

        // Single element.
        send(3, 4, 1'b1, c);
        handshake(1);

        // Length limit, without and with in_last on the eighth element.
        for (int i = 0; i < MAX_LEN; i++) send(7, 7, 1'b0, c);
        handshake(0);
        for (int i = 0; i < MAX_LEN; i++) send(7, 7, i == MAX_LEN - 1, c);
        handshake(0);

        // Ties: 20, 40, 40, 10.
        send(1, 2, 1'b0, c);
        send(2, 2, 1'b0, c);
        send(2, 2, 1'b0, c);
        send(0, 2, 1'b1, c);
        handshake(0);

        // Backpressure with input pressing against a pending summary.
        send(1, 1, 1'b0, c);
        send(2, 3, 1'b1, c);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.exp_in   = 3'($urandom_range(0, 7));
            bus.mant_in  = 3'($urandom_range(0, 7));
            bus.in_last  = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check_summary("backpressure");
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        chk("bp_release_valid", bus.out_valid, 0);
        chk("bp_release_ready", bus.in_ready, 1);
        send(5, 1, 1'b1, c);
        handshake(0);

        // Reset mid-frame, then a fresh single-element frame.
        send(4, 2, 1'b0, c);
        send(6, 5, 1'b0, c);
        pulse_reset("reset_midframe");
        send(0, 0, 1'b1, c);
        handshake(0);

        // Reset while a summary is pending.
        send(2, 6, 1'b1, c);
        pulse_reset("reset_report");

        // Randomized frames, lengths beyond MAX_LEN exercise truncation.
        for (int f = 0; f < 30; f++) begin
            int len;
            len = $urandom_range(1, 10);
            for (int i = 0; i < len; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                send($urandom_range(0, 7), $urandom_range(0, 7), i == len - 1, c);
                if (c) handshake($urandom_range(0, 3));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
